// File: rtl/gen3_scrambler_ctrl_if.sv
// gen3_scrambler_ctrl_if
//   Word-level bus between the lane datapath and the 128b/130b scrambler
//   sequencer. The master drives the incoming word, sync header and LFSR
//   keystream. The slave returns the LFSR controls, the lane seed and the
//   registered (de)scrambled word with its side-band.
//   Optional: SCRAMBLER_BYPASS_EN adds scr_bypass (master -> slave).
interface gen3_scrambler_ctrl_if;
  logic        blk_start;
  logic        data_valid;
  logic [1:0]  sync_hdr;
  logic [15:0] data_in;
  logic [15:0] lfsr_data;
  logic        lfsr_advance;
  logic        lfsr_load;
  logic [23:0] seed_value;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        blk_start_out;
  logic [1:0]  sync_hdr_out;
  logic        hdr_err;
  logic        align_err;
`ifdef SCRAMBLER_BYPASS_EN
  logic        scr_bypass;
`endif

  modport master (
`ifdef SCRAMBLER_BYPASS_EN
    output scr_bypass,
`endif
    output blk_start, data_valid, sync_hdr, data_in, lfsr_data,
    input  lfsr_advance, lfsr_load, seed_value, data_out, data_out_valid,
           blk_start_out, sync_hdr_out, hdr_err, align_err
  );

  modport slave (
`ifdef SCRAMBLER_BYPASS_EN
    input  scr_bypass,
`endif
    input  blk_start, data_valid, sync_hdr, data_in, lfsr_data,
    output lfsr_advance, lfsr_load, seed_value, data_out, data_out_valid,
           blk_start_out, sync_hdr_out, hdr_err, align_err
  );
endinterface

// File: rtl/gen3_scrambler_ctrl.sv
// gen3_scrambler_ctrl
//   Per-lane sequencer for the 8GT/s 128b/130b scrambler, 16-bit word path,
//   8 words per block. Classifies each block from its sync header and symbol 0,
//   drives the external 23-bit LFSR (advance / seed reload) and XORs the
//   payload with the keystream. One pclk of latency to data_out.
// Ports
//   pclk, reset_n  clock, asynchronous active-low reset
//   bus (slave)    blk_start/data_valid/sync_hdr/data_in/lfsr_data in;
//                  lfsr_advance/lfsr_load (combinational), seed_value
//                  (constant), data_out/data_out_valid/blk_start_out/
//                  sync_hdr_out/hdr_err/align_err (registered) out.
//   hdr_err and align_err are registered alongside the offending word, so
//   they line up with it on data_out.
// Configuration
//   SCRAMBLER_BYPASS_EN: scr_bypass=1 forces data_out=data_in while the
//   LFSR sequencing stays unchanged.
module gen3_scrambler_ctrl #(
  parameter int LANE      = 0,
  parameter int SKP_WORDS = 8
) (
  input logic                  pclk,
  input logic                  reset_n,
  gen3_scrambler_ctrl_if.slave bus
);
  localparam int BLK_WORDS = 8;
  localparam int MAX_WORDS = (SKP_WORDS > BLK_WORDS) ? SKP_WORDS : BLK_WORDS;
  localparam int CW        = $clog2(MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_OS, S_SKP, S_EIEOS, S_BAD} state_t;

  function automatic logic [23:0] lane_seed(input int l);
    case (l % 8)
      0:       return 24'h1DBFBC;
      1:       return 24'h0607BB;
      2:       return 24'h1EC760;
      3:       return 24'h18C0DB;
      4:       return 24'h010F12;
      5:       return 24'h19CFC9;
      6:       return 24'h0277CE;
      default: return 24'h1BB807;
    endcase
  endfunction

  state_t        state, state_nx, cls, cur;
  logic [CW-1:0] word_cnt, cnt_nx, idx, last_idx;
  logic          new_blk, last;
  logic [15:0]   mask, key_mask;
  logic          advance, load, hdr_err_nx, align_err_nx;

  assign bus.seed_value = lane_seed(LANE);

  // Block type as seen on word 0
  always_comb begin
    cls = S_BAD;
    case (bus.sync_hdr)
      2'b10: cls = S_DATA;
      2'b01: begin
        if (bus.data_in[7:0] == 8'h00)      cls = S_EIEOS;
        else if (bus.data_in[7:0] == 8'hAA) cls = S_SKP;
        else                                cls = S_OS;
      end
      default: cls = S_BAD;
    endcase
  end

  // A blk_start always restarts at word 0, abandoning whatever was running
  assign new_blk  = bus.data_valid & bus.blk_start;
  assign cur      = new_blk ? cls : state;
  assign idx      = new_blk ? '0 : word_cnt;
  assign last_idx = (cur == S_SKP) ? CW'(SKP_WORDS - 1) : CW'(BLK_WORDS - 1);
  assign last     = (idx == last_idx);

  // State register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      word_cnt <= cnt_nx;
    end
  end

  // Next state: only valid words move the sequencer
  always_comb begin
    state_nx = state;
    cnt_nx   = word_cnt;
    if (bus.data_valid) begin
      if (cur == S_IDLE || last) begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end else begin
        state_nx = cur;
        cnt_nx   = idx + CW'(1);
      end
    end
  end

  // Outputs for the current word
  always_comb begin
    mask         = '0;
    advance      = 1'b0;
    load         = 1'b0;
    hdr_err_nx   = 1'b0;
    align_err_nx = 1'b0;
    if (bus.data_valid) begin
      case (cur)
        S_DATA: begin
          mask    = 16'hFFFF;
          advance = 1'b1;
        end
        S_OS: begin
          // symbol 0 of an ordered set identifies it and stays in clear
          mask    = (idx == '0) ? 16'hFF00 : 16'hFFFF;
          advance = 1'b1;
        end
        S_EIEOS: load = last;
        default: ;
      endcase
      hdr_err_nx   = new_blk && (cls == S_BAD);
      align_err_nx = new_blk && (word_cnt != '0);
    end
  end

`ifdef SCRAMBLER_BYPASS_EN
  assign key_mask = bus.scr_bypass ? 16'h0000 : mask;
`else
  assign key_mask = mask;
`endif

  // Gated so the LFSR sees no strobes while reset is held
  assign bus.lfsr_advance = advance & reset_n;
  assign bus.lfsr_load    = load & reset_n;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      bus.blk_start_out  <= 1'b0;
      bus.sync_hdr_out   <= '0;
      bus.hdr_err        <= 1'b0;
      bus.align_err      <= 1'b0;
    end else begin
      bus.data_out_valid <= bus.data_valid;
      bus.blk_start_out  <= new_blk;
      bus.hdr_err        <= hdr_err_nx;
      bus.align_err      <= align_err_nx;
      if (bus.data_valid) begin
        bus.data_out     <= bus.data_in ^ (bus.lfsr_data & key_mask);
        bus.sync_hdr_out <= bus.sync_hdr;
      end
    end
  end
endmodule
